// File: rtl/uart_cmd_decoder_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder_pkg
//  Shared definitions for the UART command decoder slice: the command and
//  acknowledge byte values (the same values the master top uses), the ACK
//  FSM state encoding and a helper that classifies a received byte.
// ---------------------------------------------------------------------------
package uart_cmd_decoder_pkg;

  localparam logic [7:0] CMD_ON     = 8'h6E;
  localparam logic [7:0] CMD_OFF    = 8'h55;
  localparam logic [7:0] CMD_TOGGLE = 8'hC3;
  localparam logic [7:0] ACK_BYTE   = 8'h6B;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK_REQ  = 2'd1,
    ACK_WAIT = 2'd2
  } ack_state_t;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_ON     = 2'd1,
    OP_OFF    = 2'd2,
    OP_TOGGLE = 2'd3
  } cmd_op_t;

  // Maps a raw byte to the command it encodes; OP_NONE means "unknown byte".
  function automatic cmd_op_t decode_cmd(input logic [7:0] b);
    case (b)
      CMD_ON:     return OP_ON;
      CMD_OFF:    return OP_OFF;
      CMD_TOGGLE: return OP_TOGGLE;
      default:    return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder_if
//  Byte-level link between uart_rx/uart_tx and the command decoder.
//   data_received [7:0]  received byte, valid while rx_done=1
//   rx_done              one-cycle receive strobe
//   parity_error         qualifies rx_done; 1 = byte corrupt
//   tx_busy              transmitter busy flag
//   start_tx             transmit start request
//   data_to_tx    [7:0]  byte to transmit
//  Modports: slave = decoder side, master = UART side.
// ---------------------------------------------------------------------------
interface uart_cmd_decoder_if;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;
  logic       tx_busy;
  logic       start_tx;
  logic [7:0] data_to_tx;

  modport slave (
    input  data_received, rx_done, parity_error, tx_busy,
    output start_tx, data_to_tx
  );

  modport master (
    output data_received, rx_done, parity_error, tx_busy,
    input  start_tx, data_to_tx
  );
endinterface

// File: rtl/uart_cmd_decoder_cmd_watchdog.sv
// ---------------------------------------------------------------------------
// cmd_watchdog
//  Link-silence watchdog. Counts down from WDOG_CYCLES-1 after reset or a
//  reload and asserts expire while the count sits at zero. WDOG_CYCLES=0
//  disables it (expire tied low).
//  Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-low reset (reloads the counter)
//   reload  in  valid command seen this cycle
//   expire  out 1 while the counter holds zero
// ---------------------------------------------------------------------------
module cmd_watchdog
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 24_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic expire
);

  generate
    if (WDOG_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, reload};
      assign expire = 1'b0;
    end else begin : g_on
      localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
      localparam logic [CW-1:0] RELOAD_VAL = CW'(WDOG_CYCLES - 1);

      logic [CW-1:0] count;

      // Saturates at zero so expire stays asserted until the next reload.
      always_ff @(posedge clk) begin
        if (!reset || reload) begin
          count <= RELOAD_VAL;
        end else if (count != '0) begin
          count <= count - CW'(1);
        end
      end

      assign expire = (count == '0);
    end
  endgenerate

endmodule

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
//  Receive-side command stage: decodes ON/OFF/TOGGLE bytes from uart_rx into
//  the registered pwm_en gate, counts corrupt and unknown bytes, forces
//  pwm_en low when the link goes silent, and (optionally) answers every
//  accepted command with an ACK byte through uart_tx.
//  Build option: define CMD_ACK_EN to include the ACK FSM; without it
//  start_tx is tied 0, data_to_tx is tied 8'h00 and tx_busy is ignored.
//  Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-low reset
//   bus              slave modport of uart_cmd_decoder_if (rx/tx byte link)
//   pwm_en           out  gate to SPWM stage
//   wdog_trip        out  sticky watchdog-expired flag
//   err_parity_cnt   out  saturating count of parity-error bytes
//   err_unknown_cnt  out  saturating count of unknown bytes
// ---------------------------------------------------------------------------
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 24_000_000,
  parameter int unsigned BUSY_TMO    = 64
) (
  input  logic                clk,
  input  logic                reset,
  uart_cmd_decoder_if.slave   bus,
  output logic                pwm_en,
  output logic                wdog_trip,
  output logic [7:0]          err_parity_cnt,
  output logic [7:0]          err_unknown_cnt
);

  cmd_op_t op;
  logic    cmd_valid;
  logic    unknown_byte;
  logic    corrupt_byte;
  logic    wdog_expire;

  // Only a clean strobe can carry a command; corrupt bytes never decode.
  always_comb begin
    op = OP_NONE;
    if (bus.rx_done && !bus.parity_error) begin
      op = decode_cmd(bus.data_received);
    end
  end

  assign cmd_valid    = (op != OP_NONE);
  assign corrupt_byte = bus.rx_done && bus.parity_error;
  assign unknown_byte = bus.rx_done && !bus.parity_error && (op == OP_NONE);

  cmd_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .reload (cmd_valid),
    .expire (wdog_expire)
  );

  // A command on the expiry cycle wins over the watchdog.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_en          <= 1'b0;
      wdog_trip       <= 1'b0;
      err_parity_cnt  <= 8'h00;
      err_unknown_cnt <= 8'h00;
    end else begin
      if (corrupt_byte && err_parity_cnt != 8'hFF) begin
        err_parity_cnt <= err_parity_cnt + 8'h01;
      end
      if (unknown_byte && err_unknown_cnt != 8'hFF) begin
        err_unknown_cnt <= err_unknown_cnt + 8'h01;
      end

      case (op)
        OP_ON:     pwm_en <= 1'b1;
        OP_OFF:    pwm_en <= 1'b0;
        OP_TOGGLE: pwm_en <= ~pwm_en;
        default:   if (wdog_expire) pwm_en <= 1'b0;
      endcase

      if (cmd_valid) begin
        wdog_trip <= 1'b0;
      end else if (wdog_expire) begin
        wdog_trip <= 1'b1;
      end
    end
  end

`ifdef CMD_ACK_EN
  localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

  ack_state_t      state;
  ack_state_t      state_next;
  logic            ack_pending;
  logic            leave_req;
  logic [TW-1:0]   tmo_cnt;
  logic            start_tx_c;
  logic [7:0]      data_to_tx_c;

  // ack_pending is a single bit, so commands during an ack coalesce; a new
  // command on the cycle the pending flag is consumed keeps it set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ack_pending <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_next;
      ack_pending <= cmd_valid | (ack_pending & ~leave_req);
      tmo_cnt     <= (state == ACK_REQ) ? tmo_cnt + TW'(1) : '0;
    end
  end

  // Outputs are decoded from the state, so data_to_tx cannot move while
  // start_tx is high and both drop on the same edge as a reset.
  always_comb begin
    state_next   = state;
    leave_req    = 1'b0;
    start_tx_c   = 1'b0;
    data_to_tx_c = 8'h00;
    case (state)
      IDLE: begin
        if (ack_pending && !bus.tx_busy) state_next = ACK_REQ;
      end
      ACK_REQ: begin
        start_tx_c   = 1'b1;
        data_to_tx_c = ACK_BYTE;
        if (bus.tx_busy) begin
          state_next = ACK_WAIT;
          leave_req  = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = IDLE;
          leave_req  = 1'b1;
        end
      end
      ACK_WAIT: begin
        if (!bus.tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.start_tx   = start_tx_c;
  assign bus.data_to_tx = data_to_tx_c;
`else
  localparam int unsigned unused_busy_tmo = BUSY_TMO;
  logic unused_tx_busy;
  assign unused_tx_busy = bus.tx_busy;

  assign bus.start_tx   = 1'b0;
  assign bus.data_to_tx = 8'h00;
`endif

endmodule
